hh_spike_detector: RTL and testbench

- Downstream consumer of the HH neuron membrane-voltage output: a 14-bit signed fixed-point value, 9 integer bits and 5 fraction bits, where 32 LSB = 1 mV.
- Detects threshold crossings with hysteresis and refractory blanking, and counts spikes.
- Measures the inter-spike interval (ISI) in integration steps and emits one ISI event per spike on a valid/ready interface for readout logic.

---
 rtl/hh_spike_detector.sv | 149 ++++++++++++++
 tb/tb_hh_spike_detector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hh_spike_detector.sv
// Spike detector for the HH neuron membrane voltage: threshold crossing with
// hysteresis and refractory blanking, a saturating spike count, and ISI events.
module hh_spike_detector #(
    parameter logic signed [13:0] THRESH        = 14'sd0,
    parameter logic signed [13:0] HYST          = 14'sd320,
    parameter logic [7:0]         REFRACT_STEPS = 8'd20,
    parameter int                 CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [13:0]      voltage,
    input  logic                    v_valid,
    input  logic                    clr,
    output logic                    spike,
    output logic [CNT_W-1:0]        spike_count,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [CNT_W-1:0]        ev_isi,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        BELOW   = 2'd0,
        ABOVE   = 2'd1,
        REFRACT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Re-arm level is formed one bit wider so THRESH-HYST never wraps.
    localparam logic signed [14:0] REARM_LVL =
        $signed({THRESH[13], THRESH}) - $signed({HYST[13], HYST});

    state_t             state_q, state_d;
    logic [7:0]         refract_q, refract_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   isi_q, isi_d;
    logic               ev_valid_q, ev_valid_d;
    logic               overflow_q, overflow_d;
    logic               spike_q, spike_d;

    logic               fire;
    logic               accept;
    logic [CNT_W-1:0]   step_inc;
    logic signed [14:0] volt_ext;

    assign volt_ext = {voltage[13], voltage};
    assign step_inc = (step_q == CNT_MAX) ? CNT_MAX : step_q + CNT_W'(1);
    assign accept   = ev_valid_q & ev_ready;

    always_comb begin
        state_d   = state_q;
        refract_d = refract_q;
        fire      = 1'b0;
        if (v_valid) begin
            case (state_q)
                BELOW: begin
                    if (voltage >= THRESH) begin
                        fire    = 1'b1;
                        state_d = ABOVE;
                    end
                end
                ABOVE: begin
                    if (volt_ext < REARM_LVL) begin
                        if (REFRACT_STEPS == 8'd0) begin
                            state_d = BELOW;
                        end else begin
                            state_d   = REFRACT;
                            refract_d = REFRACT_STEPS;
                        end
                    end
                end
                REFRACT: begin
                    refract_d = refract_q - 8'd1;
                    if (refract_q <= 8'd1) begin
                        state_d   = BELOW;
                        refract_d = 8'd0;
                    end
                end
                default: begin
                    state_d   = BELOW;
                    refract_d = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        spike_d    = fire;
        step_d     = step_q;
        count_d    = count_q;
        isi_d      = isi_q;
        ev_valid_d = ev_valid_q & ~accept;
        overflow_d = overflow_q;

        if (v_valid) begin
            step_d = fire ? '0 : step_inc;
        end

        if (fire && count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end

        // A spike may reuse the holding register in the cycle it drains.
        if (fire) begin
            if (!ev_valid_q || accept) begin
                ev_valid_d = 1'b1;
                isi_d      = step_inc;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (clr) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BELOW;
            refract_q  <= 8'd0;
            step_q     <= '0;
            count_q    <= '0;
            isi_q      <= '0;
            ev_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            spike_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            refract_q  <= refract_d;
            step_q     <= step_d;
            count_q    <= count_d;
            isi_q      <= isi_d;
            ev_valid_q <= ev_valid_d;
            overflow_q <= overflow_d;
            spike_q    <= spike_d;
        end
    end

    assign spike       = spike_q;
    assign spike_count = count_q;
    assign ev_valid    = ev_valid_q;
    assign ev_isi      = isi_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_hh_spike_detector.sv
// Bench for hh_spike_detector: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the detector.
module tb_hh_spike_detector;

    localparam int MODEL_REFRACT = 4;
    localparam int THRESH_MV     = 0;
    localparam int HYST_MV       = 320;
    localparam int MAXC          = 65535;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [13:0] voltage = '0;
    logic               v_valid = 1'b0;
    logic               clr = 1'b0;
    logic               ev_ready = 1'b1;
    logic               spike;
    logic [15:0]        spike_count;
    logic               ev_valid;
    logic [15:0]        ev_isi;
    logic               overflow;

    int checks = 0;
    int failures = 0;

    hh_spike_detector #(
        .THRESH(14'sd0),
        .HYST(14'sd320),
        .REFRACT_STEPS(8'(MODEL_REFRACT)),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .voltage(voltage),
        .v_valid(v_valid),
        .clr(clr),
        .spike(spike),
        .spike_count(spike_count),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_isi(ev_isi),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // The model tracks "waiting for a dip", a blanking budget and samples since
    // the last spike; the event register is a one-slot mailbox.
    typedef struct packed {
        logic above;
        int   blank;
        int   since;
        int   count;
        logic evValid;
        int   evIsi;
        logic ovf;
        logic spk;
    } model_t;

    model_t m;

    function automatic model_t modelStep(model_t s, int v, logic vv, logic rdy, logic clrIn);
        model_t n;
        logic   fire;
        logic   accept;
        int     isi;
        n      = s;
        fire   = 1'b0;
        accept = s.evValid && rdy;
        isi    = (s.since + 1 > MAXC) ? MAXC : s.since + 1;
        n.spk  = 1'b0;
        if (vv) begin
            if (s.blank > 0) begin
                n.blank = s.blank - 1;
            end else if (!s.above) begin
                if (v >= THRESH_MV) begin
                    fire    = 1'b1;
                    n.above = 1'b1;
                end
            end else if (v < THRESH_MV - HYST_MV) begin
                n.above = 1'b0;
                n.blank = MODEL_REFRACT;
            end
            n.since = fire ? 0 : isi;
        end
        if (accept) n.evValid = 1'b0;
        if (fire) begin
            n.spk = 1'b1;
            if (s.count < MAXC) n.count = s.count + 1;
            if (!s.evValid || accept) begin
                n.evValid = 1'b1;
                n.evIsi   = isi;
            end else begin
                n.ovf = 1'b1;
            end
        end
        if (clrIn) begin
            n.count = 0;
            n.ovf   = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= modelStep(m, int'(voltage), v_valid, ev_ready, clr);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("spike",       int'(spike),       int'(m.spk));
            checkOutput("spike_count", int'(spike_count), m.count);
            checkOutput("ev_valid",    int'(ev_valid),    int'(m.evValid));
            checkOutput("ev_isi",      int'(ev_isi),      m.evIsi);
            checkOutput("overflow",    int'(overflow),    int'(m.ovf));
        end
    end

    // Drives one cycle's inputs just after a clock edge and returns just after
    // the edge that samples them.
    task automatic applyStimulus(input int v, input logic vv);
        voltage = 14'(v);
        v_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        checkOutput("reset_spike",       int'(spike),       0);
        checkOutput("reset_spike_count", int'(spike_count), 0);
        checkOutput("reset_ev_valid",    int'(ev_valid),    0);
        checkOutput("reset_overflow",    int'(overflow),    0);
        rst = 1'b0;

        $display("[TB] quiescent baseline");
        for (int i = 0; i < 10; i++) applyStimulus(-2080, 1'b1);
        checkOutput("quiet_count", int'(spike_count), 0);
        checkOutput("quiet_ev_valid", int'(ev_valid), 0);

        $display("[TB] first crossing");
        doReset();
        applyStimulus(-2080, 1'b1);
        applyStimulus(-1600, 1'b1);
        applyStimulus(-1200, 1'b1);
        applyStimulus(-800, 1'b1);
        applyStimulus(-400, 1'b1);
        applyStimulus(-100, 1'b1);
        checkOutput("pre_cross_spike", int'(spike), 0);
        applyStimulus(0, 1'b1);
        checkOutput("cross_spike", int'(spike), 1);
        checkOutput("cross_count", int'(spike_count), 1);
        checkOutput("cross_ev_valid", int'(ev_valid), 1);
        checkOutput("cross_ev_isi", int'(ev_isi), 7);

        $display("[TB] hysteresis");
        applyStimulus(0, 1'b1);
        checkOutput("spike_one_cycle", int'(spike), 0);
        applyStimulus(-160, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(32, 1'b1);
        checkOutput("hyst_count", int'(spike_count), 1);

        $display("[TB] refractory");
        applyStimulus(-640, 1'b1);
        applyStimulus(32, 1'b1);
        checkOutput("refract_ignored", int'(spike), 0);
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(-640, 1'b1);
        applyStimulus(32, 1'b1);
        checkOutput("refract_spike", int'(spike), 1);
        checkOutput("refract_count", int'(spike_count), 2);
        checkOutput("refract_ev_isi", int'(ev_isi), 11);

        $display("[TB] backpressure");
        doReset();
        ev_ready = 1'b0;
        applyStimulus(32, 1'b1);
        checkOutput("bp_first_isi", int'(ev_isi), 1);
        for (int i = 0; i < 5; i++) applyStimulus(-2080, 1'b1);
        applyStimulus(32, 1'b1);
        checkOutput("bp_count", int'(spike_count), 2);
        checkOutput("bp_overflow", int'(overflow), 1);
        checkOutput("bp_held_isi", int'(ev_isi), 1);
        checkOutput("bp_held_valid", int'(ev_valid), 1);
        ev_ready = 1'b1;
        applyStimulus(32, 1'b0);
        checkOutput("bp_drained", int'(ev_valid), 0);
        clr = 1'b1;
        applyStimulus(32, 1'b0);
        clr = 1'b0;
        checkOutput("clr_count", int'(spike_count), 0);
        checkOutput("clr_overflow", int'(overflow), 0);

        $display("[TB] reset mid-ABOVE");
        for (int i = 0; i < 5; i++) applyStimulus(-2080, 1'b1);
        applyStimulus(32, 1'b1);
        checkOutput("pre_rst_isi", int'(ev_isi), 6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_count", int'(spike_count), 0);
        checkOutput("async_rst_ev_valid", int'(ev_valid), 0);
        checkOutput("async_rst_ev_isi", int'(ev_isi), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(32, 1'b1);
        checkOutput("post_rst_spike", int'(spike), 1);
        checkOutput("post_rst_isi", int'(ev_isi), 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            ev_ready = ($urandom_range(0, 1) == 1);
            clr      = ($urandom_range(0, 49) == 0);
            applyStimulus(int'($urandom_range(0, 2880)) - 2080, ($urandom_range(0, 4) != 0));
        end
        clr = 1'b0;
        applyStimulus(-2080, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
